// File: rtl/apb_uart_console_arb_if.sv
// Bundles the requester byte streams and the APB master bus of apb_uart_console_arb.
// The master modport is the arbiter's view; slave is the view of the surrounding system.
interface apb_uart_console_arb_if #(
    parameter int NUM_REQ        = 2,
    parameter int APB_ADDR_WIDTH = 12
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*8-1:0]      req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [APB_ADDR_WIDTH-1:0] M_PADDR;
    logic [31:0]               M_PWDATA;
    logic                      M_PWRITE;
    logic                      M_PSEL;
    logic                      M_PENABLE;
    logic [31:0]               M_PRDATA;
    logic                      M_PREADY;
    logic                      M_PSLVERR;
    logic                      busy_o;
    logic                      err_o;

    modport master (
        input  req_valid_i, req_data_i, M_PRDATA, M_PREADY, M_PSLVERR,
        output req_ready_o, M_PADDR, M_PWDATA, M_PWRITE, M_PSEL, M_PENABLE, busy_o, err_o
    );

    modport slave (
        output req_valid_i, req_data_i, M_PRDATA, M_PREADY, M_PSLVERR,
        input  req_ready_o, M_PADDR, M_PWDATA, M_PWRITE, M_PSEL, M_PENABLE, busy_o, err_o
    );
endinterface

// File: rtl/apb_uart_console_arb.sv
// Line-granular round-robin sharing of one APB 16550-style UART transmitter (LSR poll, THR write).
// Optional UART_ARB_PREFIX_EN: each burst is prefixed with "<grant digit>:".
module apb_uart_console_arb #(
    parameter int          NUM_REQ        = 2,
    parameter int          LINE_DEPTH     = 16,
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int unsigned THR_ADDR       = 0,
    parameter int unsigned LSR_ADDR       = 5
) (
    input logic                    CLK,
    input logic                    RSTN,
    apb_uart_console_arb_if.master bus
);
    localparam int AW = $clog2(LINE_DEPTH);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] NL = 8'h0A;

    typedef enum logic [2:0] {IDLE, POLL_S, POLL_A, WR_S, WR_A} state_t;

    state_t             state, state_nx;
    logic [7:0]         mem    [NUM_REQ][LINE_DEPTH];
    logic [AW-1:0]      wr_ptr [NUM_REQ];
    logic [AW-1:0]      rd_ptr [NUM_REQ];
    logic [AW:0]        count  [NUM_REQ];
    logic [AW:0]        nl_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] push, pop, full, eligible, nl_in, nl_out;
    logic [GW-1:0]      grant, rr, pick;
    logic               pick_vld;
    logic [AW:0]        sent;
    logic [7:0]         head, tx_byte;
    logic               xfer_done, last_byte, prefix_active, err_q;
    logic               unused_prdata;

    assign unused_prdata = ^{bus.M_PRDATA[31:6], bus.M_PRDATA[4:0]};
    assign head      = mem[grant][rd_ptr[grant]];
    assign xfer_done = (state == WR_A) && bus.M_PREADY;
    assign last_byte = !prefix_active && ((head == NL) || (sent == (AW+1)'(LINE_DEPTH-1)));

    // Eligibility looks at this cycle's push so a newline can be granted at the edge it arrives.
    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
        push     = '0;
        pop      = '0;
        full     = '0;
        eligible = '0;
        nl_in    = '0;
        nl_out   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            full[i]     = (count[i] == (AW+1)'(LINE_DEPTH));
            push[i]     = bus.req_valid_i[i] && !full[i];
            pop[i]      = xfer_done && !prefix_active && (grant == GW'(i));
            nl_in[i]    = push[i] && (bus.req_data_i[8*i +: 8] == NL);
            nl_out[i]   = pop[i] && (head == NL);
            eligible[i] = (nl_cnt[i] != '0) || full[i] || nl_in[i] ||
                          (push[i] && (count[i] == (AW+1)'(LINE_DEPTH-1)));
        end
    end

    assign bus.req_ready_o = ~full;

    // NOTE: line storage has no reset; emptiness is tracked by the reset pointers and counts.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REQ; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= bus.req_data_i[8*i +: 8];
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                nl_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + (AW+1)'(1);
                else if (!push[i] && pop[i]) count[i] <= count[i] - (AW+1)'(1);
                if (nl_in[i] && !nl_out[i])      nl_cnt[i] <= nl_cnt[i] + (AW+1)'(1);
                else if (!nl_in[i] && nl_out[i]) nl_cnt[i] <= nl_cnt[i] - (AW+1)'(1);
            end
        end
    end

    // First eligible buffer at or after rr; descending scan so the smallest offset wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[GW'((int'(rr) + k) % NUM_REQ)]) begin
                pick     = GW'((int'(rr) + k) % NUM_REQ);
                pick_vld = 1'b1;
            end
        end
    end

`ifdef UART_ARB_PREFIX_EN
    logic [1:0] pfx;
    assign prefix_active = (pfx != 2'd2);
    assign tx_byte = !prefix_active ? head : (pfx == 2'd0) ? 8'h30 + 8'(grant) : 8'h3A;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)                             pfx <= 2'd2;
        else if (state == IDLE && pick_vld)    pfx <= 2'd0;
        else if (xfer_done && prefix_active)   pfx <= pfx + 2'd1;
    end
`else
    assign prefix_active = 1'b0;
    assign tx_byte       = head;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            grant <= '0;
            rr    <= '0;
            sent  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= xfer_done && bus.M_PSLVERR;
            if (state == IDLE && pick_vld) begin
                grant <= pick;
                sent  <= '0;
            end else if (xfer_done && !prefix_active) begin
                sent <= sent + (AW+1)'(1);
            end
            if (xfer_done && last_byte)
                rr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_vld) state_nx = POLL_S;
            POLL_S:  state_nx = POLL_A;
            POLL_A:  if (bus.M_PREADY)
                         state_nx = (bus.M_PRDATA[5] && !bus.M_PSLVERR) ? WR_S : POLL_S;
            WR_S:    state_nx = WR_A;
            WR_A:    if (bus.M_PREADY) state_nx = last_byte ? IDLE : POLL_S;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o    = (state != IDLE);
        bus.err_o     = err_q;
        bus.M_PSEL    = (state != IDLE);
        bus.M_PENABLE = (state == POLL_A) || (state == WR_A);
        bus.M_PWRITE  = (state == WR_S) || (state == WR_A);
        bus.M_PADDR   = '0;
        bus.M_PWDATA  = '0;
        if (state == POLL_S || state == POLL_A) bus.M_PADDR = APB_ADDR_WIDTH'(LSR_ADDR);
        if (state == WR_S || state == WR_A)     bus.M_PADDR = APB_ADDR_WIDTH'(THR_ADDR);
        if (state != IDLE)                      bus.M_PWDATA = {24'b0, tx_byte};
    end
endmodule

// File: tb/tb_apb_uart_console_arb.sv
// Directed bench for apb_uart_console_arb with a behavioural APB UART slave and protocol monitor.
module tb_apb_uart_console_arb;
    localparam int NUM_REQ = 2;
    localparam int LINE_DEPTH = 16;
    localparam int AWID = 12;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    apb_uart_console_arb_if #(.NUM_REQ(NUM_REQ), .APB_ADDR_WIDTH(AWID)) bus ();

    apb_uart_console_arb #(
        .NUM_REQ(NUM_REQ), .LINE_DEPTH(LINE_DEPTH), .APB_ADDR_WIDTH(AWID),
        .THR_ADDR(0), .LSR_ADDR(5)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model and monitor state
    int rd_cnt, wr_waits, wait_cnt, busy_polls, err_idx, wr_idx;
    int proto_err, err_cycles, busy_cycles, rd_before_first;
    logic [7:0] wr_q[$];
    logic thre_ok;
    logic [AWID-1:0] s_addr;
    logic [31:0] s_wdata;
    logic s_write;

    task automatic clear_model();
        rd_cnt = 0; wr_waits = 0; wait_cnt = 0; busy_polls = 0; err_idx = -1; wr_idx = 0;
        proto_err = 0; err_cycles = 0; busy_cycles = 0; rd_before_first = -1;
        wr_q.delete();
        thre_ok = 1'b0;
    endtask

    // Slave answers at the falling edge; a transfer completes at the following rising edge.
    always @(negedge CLK) begin
        if (!RSTN) begin
            bus.M_PREADY = 1'b0; bus.M_PSLVERR = 1'b0; bus.M_PRDATA = '0;
            wait_cnt = 0;
        end else begin
            if (bus.busy_o) busy_cycles++;
            if (bus.err_o) err_cycles++;
            if (bus.M_PENABLE && !bus.M_PSEL) proto_err++;
            if (!bus.busy_o && bus.M_PSEL) proto_err++;
            if (bus.M_PSEL && !bus.M_PENABLE) begin
                s_addr = bus.M_PADDR; s_wdata = bus.M_PWDATA; s_write = bus.M_PWRITE;
                if (bus.M_PADDR !== (bus.M_PWRITE ? 12'd0 : 12'd5)) proto_err++;
                bus.M_PREADY = 1'b0; bus.M_PSLVERR = 1'b0;
            end else if (bus.M_PSEL && bus.M_PENABLE) begin
                if (bus.M_PADDR !== s_addr || bus.M_PWRITE !== s_write ||
                    (s_write && bus.M_PWDATA !== s_wdata)) proto_err++;
                if (s_write && wait_cnt < wr_waits) begin
                    wait_cnt++;
                    bus.M_PREADY = 1'b0; bus.M_PSLVERR = 1'b0;
                end else begin
                    wait_cnt = 0;
                    bus.M_PREADY = 1'b1;
                    if (s_write) begin
                        if (!thre_ok) proto_err++;
                        thre_ok = 1'b0;
                        if (wr_q.size() == 0) rd_before_first = rd_cnt;
                        wr_q.push_back(bus.M_PWDATA[7:0]);
                        bus.M_PSLVERR = (wr_idx == err_idx);
                        bus.M_PRDATA = '0;
                        wr_idx++;
                    end else begin
                        rd_cnt++;
                        bus.M_PSLVERR = 1'b0;
                        if (busy_polls > 0) begin
                            bus.M_PRDATA = 32'h0000_0000; busy_polls--; thre_ok = 1'b0;
                        end else begin
                            bus.M_PRDATA = 32'h0000_0060; thre_ok = 1'b1;
                        end
                    end
                end
            end else begin
                bus.M_PREADY = 1'b0; bus.M_PSLVERR = 1'b0;
            end
        end
    end

    task automatic push_one(input int idx, input logic [7:0] b);
        @(negedge CLK);
        bus.req_valid_i = '0;
        bus.req_valid_i[idx] = 1'b1;
        bus.req_data_i[8*idx +: 8] = b;
        @(posedge CLK); #1;
        bus.req_valid_i = '0;
    endtask

    task automatic push_pair(input logic [7:0] b0, input logic [7:0] b1);
        @(negedge CLK);
        bus.req_valid_i = 2'b11;
        bus.req_data_i = {b1, b0};
        @(posedge CLK); #1;
        bus.req_valid_i = '0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (wr_q.size() < n && c < budget) begin
            @(posedge CLK); #1;
            c++;
        end
        check(tag, wr_q.size(), n);
    endtask

    // Expected bytes packed left-to-right, first byte in the most significant position.
    task automatic check_writes(input string tag, input logic [63:0] exp, input int n);
        for (int k = 0; k < n; k++)
            check($sformatf("%s_byte%0d", tag, k),
                  (k < wr_q.size()) ? {24'b0, wr_q[k]} : 32'hFFFF_FFFF,
                  {24'b0, exp[8*(n-1-k) +: 8]});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTN = 1'b0;
        clear_model();
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.req_valid_i = '0;
        bus.req_data_i = '0;
        bus.M_PRDATA = '0;
        bus.M_PREADY = 1'b0;
        bus.M_PSLVERR = 1'b0;
        clear_model();

        // Reset values
        repeat (2) @(negedge CLK);
        check("rst_ready", bus.req_ready_o, 2'b11);
        check("rst_psel", bus.M_PSEL, 0);
        check("rst_penable", bus.M_PENABLE, 0);
        check("rst_pwrite", bus.M_PWRITE, 0);
        check("rst_paddr", bus.M_PADDR, 0);
        check("rst_pwdata", bus.M_PWDATA, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_err", bus.err_o, 0);
        RSTN = 1'b1;

        // Single line "Hi\n", zero-wait slave
        push_one(0, 8'h48);
        push_one(0, 8'h69);
        push_one(0, 8'h0A);
        check("t1_lat_psel", bus.M_PSEL, 1);
        check("t1_lat_penable", bus.M_PENABLE, 0);
        check("t1_lat_pwrite", bus.M_PWRITE, 0);
        check("t1_lat_paddr", bus.M_PADDR, 5);
        wait_writes(3, 100, "t1_nwr");
        repeat (3) @(posedge CLK); #1;
        check_writes("t1", 64'h48690A, 3);
        check("t1_reads", rd_cnt, 3);
        check("t1_busy_cycles", busy_cycles, 12);
        check("t1_busy_end", bus.busy_o, 0);
        check("t1_proto", proto_err, 0);

        // Contention: both lines complete in the same cycle
        do_reset();
        push_pair(8'h41, 8'h43);
        push_pair(8'h42, 8'h44);
        push_pair(8'h0A, 8'h0A);
        wait_writes(6, 200, "t2_nwr");
        repeat (3) @(posedge CLK); #1;
        check_writes("t2", 64'h41420A43440A, 6);
        check("t2_busy_cycles", busy_cycles, 24);
        wr_q.delete();
        push_pair(8'h78, 8'h79);
        push_pair(8'h0A, 8'h0A);
        wait_writes(4, 200, "t2b_nwr");
        repeat (3) @(posedge CLK); #1;
        check_writes("t2b", 64'h780A790A, 4);
        check("t2_proto", proto_err, 0);

        // Full buffer without newline
        do_reset();
        for (int b = 8'h30; b <= 8'h3F; b++) push_one(1, 8'(b));
        check("t3_full_ready", bus.req_ready_o, 2'b01);
        wait_writes(1, 50, "t3_first");
        check("t3_ready_back", bus.req_ready_o, 2'b11);
        wait_writes(16, 300, "t3_nwr");
        repeat (3) @(posedge CLK); #1;
        for (int k = 0; k < 16; k++)
            check($sformatf("t3_byte%0d", k), (k < wr_q.size()) ? {24'b0, wr_q[k]} : 32'hFFFF_FFFF,
                  32'h30 + 32'(k));
        check("t3_reads", rd_cnt, 16);
        check("t3_busy_end", bus.busy_o, 0);
        check("t3_proto", proto_err, 0);

        // THRE clear for three polls
        do_reset();
        busy_polls = 3;
        push_one(0, 8'h5A);
        push_one(0, 8'h0A);
        wait_writes(2, 100, "t4_nwr");
        repeat (3) @(posedge CLK); #1;
        check("t4_reads_first", rd_before_first, 4);
        check("t4_reads", rd_cnt, 5);
        check_writes("t4", 64'h5A0A, 2);
        check("t4_proto", proto_err, 0);

        // Write wait states and a slave error on the second byte
        do_reset();
        wr_waits = 2;
        err_idx = 1;
        push_one(0, 8'h61);
        push_one(0, 8'h62);
        push_one(0, 8'h63);
        push_one(0, 8'h0A);
        wait_writes(4, 300, "t5_nwr");
        repeat (3) @(posedge CLK); #1;
        check_writes("t5", 64'h6162630A, 4);
        check("t5_err_cycles", err_cycles, 1);
        check("t5_busy_cycles", busy_cycles, 24);
        check("t5_busy_end", bus.busy_o, 0);
        check("t5_proto", proto_err, 0);

        // Reset in the middle of a THR access
        do_reset();
        wr_waits = 5;
        push_one(0, 8'h78);
        push_one(0, 8'h79);
        push_one(0, 8'h7A);
        push_one(0, 8'h0A);
        c = 0;
        while (!(bus.M_PSEL && bus.M_PENABLE && bus.M_PWRITE) && c < 50) begin
            @(posedge CLK); #1;
            c++;
        end
        check("t6_in_wr_access", bus.M_PSEL && bus.M_PENABLE && bus.M_PWRITE, 1);
        RSTN = 1'b0;
        #1;
        check("t6_async_psel", bus.M_PSEL, 0);
        check("t6_async_penable", bus.M_PENABLE, 0);
        check("t6_async_ready", bus.req_ready_o, 2'b11);
        check("t6_async_busy", bus.busy_o, 0);
        repeat (2) @(negedge CLK);
        clear_model();
        RSTN = 1'b1;
        repeat (30) @(posedge CLK); #1;
        check("t6_no_writes", wr_q.size(), 0);
        check("t6_no_reads", rd_cnt, 0);
        check("t6_idle", bus.busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
